// File: rtl/hakutpu_alu_pkg.sv
// Shared constants and vector types for the FP16 ALU array and its result path.
package hakutpu_alu_pkg;
  localparam int ALU_LANES   = 16;
  localparam int FP16_W      = 16;
  localparam int ALU_LATENCY = 5;

  typedef logic [FP16_W-1:0] fp16_t;
  typedef fp16_t [0:ALU_LANES-1] alu_vec_t;
endpackage

// File: rtl/alu_tag_delay.sv
// {valid, tag} shift register that tracks each granted issue through the fixed-latency ALU.
module alu_tag_delay #(
  parameter int LAT   = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int i = 0; i < LAT; i++) tag_d[i] = '0;
    tag_d[0] = in_tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];
endmodule

// File: rtl/alu_result_fifo.sv
// Issue-credit controller and show-ahead result FIFO behind the FP16 ALU array.
// Optional per-issue tag path enabled by defining ALU_RESULT_FIFO_TAG_EN.
module alu_result_fifo
  import hakutpu_alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LANES   = ALU_LANES,
  parameter int WIDTH   = FP16_W,
  parameter int ALU_LAT = ALU_LATENCY,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_req,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_grant,
  input  logic                     alu_out_valid,
  input  logic [LANES*WIDTH-1:0]   alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [LANES*WIDTH-1:0]   res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   in_flight,
  output logic                     err_unexp,
  output logic                     err_sync
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = LANES * WIDTH;
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, in_flight_q, in_flight_d;
  logic          err_unexp_q, err_unexp_d, err_sync_q, err_sync_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [CW:0]   credit_used;
  logic          push, pop, full, dly_valid;

  // Credit counts both stored and in-flight results so the ALU never returns into a full FIFO.
  assign credit_used = {1'b0, count_q} + {1'b0, in_flight_q};
  assign issue_grant = rst && issue_req && (credit_used < DEPTH_S);

  // Consumer handshake: a beat transfers on any cycle where res_valid && res_ready;
  // res_valid never depends on res_ready, and the head stays stable until taken.
  assign full      = (count_q == DEPTH_C);
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && res_ready;
  assign push      = alu_out_valid && (!full || pop);

`ifdef ALU_RESULT_FIFO_TAG_EN
  logic [TAG_W-1:0] dly_tag;
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  alu_tag_delay #(.LAT(ALU_LAT), .TAG_W(TAG_W)) u_tag_delay (
    .clk(clk), .rst(rst), .in_valid(issue_grant), .in_tag(issue_tag),
    .out_valid(dly_valid), .out_tag(dly_tag)
  );

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= dly_tag;
  end

  assign res_tag = tag_mem_q[rd_ptr_q];
`else
  logic dly_tag_unused;
  logic tag_unused;

  alu_tag_delay #(.LAT(ALU_LAT), .TAG_W(1)) u_tag_delay (
    .clk(clk), .rst(rst), .in_valid(issue_grant), .in_tag(1'b0),
    .out_valid(dly_valid), .out_tag(dly_tag_unused)
  );

  assign tag_unused = ^issue_tag;
  assign res_tag    = '0;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    err_unexp_d = err_unexp_q;
    err_sync_d  = err_sync_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (issue_grant && !alu_out_valid)
      in_flight_d = in_flight_q + 1'b1;
    else if (!issue_grant && alu_out_valid && (in_flight_q != '0))
      in_flight_d = in_flight_q - 1'b1;
    if (alu_out_valid && (in_flight_q == '0)) err_unexp_d = 1'b1;
    if (alu_out_valid && full && !pop)        err_unexp_d = 1'b1;
    if (dly_valid != alu_out_valid)           err_sync_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      err_unexp_q <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      err_unexp_q <= err_unexp_d;
      err_sync_q  <= err_sync_d;
    end
  end

  // Result storage is left unreset; its contents are don't-care until res_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= alu_out;
  end

  assign res_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign in_flight = in_flight_q;
  assign err_unexp = err_unexp_q;
  assign err_sync  = err_sync_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: behavioural ALU model, scoreboard queue, vector table plus corner sequences.
module tb_alu_result_fifo;
  localparam int DEPTH   = 8;
  localparam int LANES   = 16;
  localparam int WIDTH   = 16;
  localparam int ALU_LAT = 5;
  localparam int TAG_W   = 4;
  localparam int DW      = LANES * WIDTH;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_req;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_grant;
  logic             alu_out_valid;
  logic [DW-1:0]    alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic [TAG_W-1:0] res_tag;
  logic [CW-1:0]    count;
  logic [CW-1:0]    in_flight;
  logic             err_unexp;
  logic             err_sync;

  alu_result_fifo #(.DEPTH(DEPTH), .LANES(LANES), .WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .issue_req(issue_req), .issue_tag(issue_tag), .issue_grant(issue_grant),
    .alu_out_valid(alu_out_valid), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .count(count), .in_flight(in_flight),
    .err_unexp(err_unexp), .err_sync(err_sync)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } beat_t;

  typedef struct {
    int   ncyc;
    logic ready;
    int   lat;
    int   exp_grants;
    int   exp_count;
    int   exp_first_valid;
    int   exp_sync_cyc;
  } vec_t;

  beat_t                  pend_q[$];
  logic [DW+TAG_W-1:0]    exp_q[$];
  vec_t                   vecs[5];

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               cyc0, grants, first_valid, first_sync, lat;
  logic             inject, g_last, cmp_tag;
  logic [TAG_W-1:0] tag_ctr;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TAG_W-1:0] exp_tag(input logic [TAG_W-1:0] t);
`ifdef ALU_RESULT_FIFO_TAG_EN
    return t;
`else
    return '0 & t;
`endif
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
    return v;
  endfunction

  // driver + ALU model + scoreboard for one clock cycle
  task automatic step();
    logic                beat;
    logic [DW-1:0]       bdata;
    logic [TAG_W-1:0]    btag;
    logic [DW+TAG_W-1:0] e;
    beat_t               b;
    beat  = 1'b0;
    bdata = '0;
    btag  = '0;
    if (inject) begin
      beat  = 1'b1;
      bdata = rand_vec();
    end else if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      b     = pend_q.pop_front();
      beat  = 1'b1;
      bdata = b.data;
      btag  = b.tag;
    end
    alu_out_valid = beat;
    alu_out       = bdata;
    issue_tag     = tag_ctr;
    #1;
    g_last = issue_grant;
    if (issue_grant) begin
      grants++;
      b.due  = cyc + lat;
      b.tag  = tag_ctr;
      b.data = rand_vec();
      pend_q.push_back(b);
      tag_ctr++;
    end
    if (res_valid && first_valid < 0) first_valid = cyc - cyc0;
    if (err_sync && first_sync < 0) first_sync = cyc - cyc0;
    if (rst) begin
      check("res_valid", res_valid, exp_q.size() != 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got res_valid=1 expected no stored entry");
        end else begin
          e = exp_q.pop_front();
          check_data("res_data", res_data, e[DW+TAG_W-1:TAG_W]);
          if (cmp_tag) check("res_tag", res_tag, e[TAG_W-1:0]);
        end
      end
      if (beat && exp_q.size() < DEPTH) exp_q.push_back({bdata, exp_tag(btag)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    issue_req     = 1'b0;
    res_ready     = 1'b0;
    alu_out_valid = 1'b0;
    inject        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
    pend_q.delete();
    exp_q.delete();
    tag_ctr = '0;
    check("rst_count", count, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err_unexp", err_unexp, 0);
    check("rst_err_sync", err_sync, 0);
  endtask

  initial begin
    rst = 1'b0; issue_req = 1'b0; issue_tag = '0; alu_out_valid = 1'b0; alu_out = '0;
    res_ready = 1'b0; inject = 1'b0; tag_ctr = '0; lat = ALU_LAT; cmp_tag = 1'b1;
    grants = 0; first_valid = -1; first_sync = -1; cyc0 = 0;

    // ncyc, ready, lat, grants, final count, first res_valid cycle, first err_sync cycle
    vecs[0] = '{10, 1'b0, 5,  8, 8, 6, -1};
    vecs[1] = '{20, 1'b1, 5, 20, 0, 6, -1};
    vecs[2] = '{ 3, 1'b0, 5,  3, 3, 6, -1};
    vecs[3] = '{10, 1'b1, 6, 10, 0, 7,  6};
    vecs[4] = '{12, 1'b0, 6,  8, 8, 7,  6};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      lat         = vecs[i].lat;
      cmp_tag     = (vecs[i].lat == ALU_LAT);
      res_ready   = vecs[i].ready;
      grants      = 0;
      first_valid = -1;
      first_sync  = -1;
      cyc0        = cyc;
      issue_req   = 1'b1;
      repeat (vecs[i].ncyc) step();
      issue_req = 1'b0;
      repeat (12) step();
      check($sformatf("v%0d_grants", i), grants, vecs[i].exp_grants);
      check($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("v%0d_in_flight", i), in_flight, 0);
      check($sformatf("v%0d_err_unexp", i), err_unexp, 0);
      check($sformatf("v%0d_first_valid", i), first_valid, vecs[i].exp_first_valid);
      check($sformatf("v%0d_first_sync", i), first_sync, vecs[i].exp_sync_cyc);
    end

    // Full FIFO: a pop frees a slot, but credit only returns on the next cycle.
    issue_req = 1'b1;
    res_ready = 1'b1;
    step();
    check("full_pop_grant", g_last, 0);
    check("full_pop_count", count, 7);
    res_ready = 1'b0;
    step();
    check("grant_after_pop", g_last, 1);
    issue_req = 1'b0;
    repeat (8) step();
    check("refill_count", count, 8);
    res_ready = 1'b1;
    repeat (10) step();
    check("drain_count", count, 0);
    check("drain_err_unexp", err_unexp, 0);

    // Unexpected beat with nothing in flight.
    do_reset();
    lat     = ALU_LAT;
    cmp_tag = 1'b1;
    inject  = 1'b1;
    step();
    inject = 1'b0;
    check("unexp_err_unexp", err_unexp, 1);
    check("unexp_err_sync", err_sync, 1);
    check("unexp_count", count, 1);
    check("unexp_in_flight", in_flight, 0);
    repeat (3) step();
    check("unexp_sticky", err_unexp, 1);
    check("sync_sticky", err_sync, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("unexp_drained", count, 0);

    // Reset with 3 stored and 2 in flight; a late ALU beat follows the reset.
    do_reset();
    cyc0      = cyc;
    issue_req = 1'b1;
    repeat (5) step();
    issue_req = 1'b0;
    repeat (3) step();
    check("pre_rst_count", count, 3);
    check("pre_rst_in_flight", in_flight, 2);
    rst       = 1'b0;
    issue_req = 1'b1;
    step();
    check("grant_in_reset", g_last, 0);
    rst       = 1'b1;
    issue_req = 1'b0;
    exp_q.delete();
    check("post_rst_count", count, 0);
    check("post_rst_in_flight", in_flight, 0);
    check("post_rst_res_valid", res_valid, 0);
    step();
    check("late_beat_err_unexp", err_unexp, 1);
    check("late_beat_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
